// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN post-convolution datapath.
//   pool_state_t : control states of the bias/ReLU/max-pool stage
//   DATA_W_DEF   : default pixel/bias width
//   MAX_OF_DEF   : default maximum number of output channels
//   QUANT_MAX    : saturation ceiling of the optional requantizer
package cnn_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned MAX_OF_DEF = 8;
   localparam int unsigned QUANT_MAX  = 127;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      EVEN_ROW = 3'd1,
      ODD_ROW  = 3'd2,
      FLUSH    = 3'd3,
      FIN      = 3'd4
   } pool_state_t;

endpackage : cnn_pkg

// File: rtl/pool_row_buffer.sv
// Row buffer holding the horizontal pair maxima of the current even row.
//   clk, rst_n       : clock, asynchronous active-low reset (clears valid flags)
//   wr_en/addr/data  : synchronous write port
//   rd_addr/rd_data  : combinational read port; unwritten entries read as 0
module pool_row_buffer #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 32,
   parameter int unsigned AW     = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0]  vld_q;
   logic [DEPTH-1:0]  vld_d;

   // Valid flag set on first write of an entry
   always_comb begin
      vld_d = vld_q;
      if (wr_en) vld_d[wr_addr] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_q <= '0;
      else        vld_q <= vld_d;
   end

   // Storage array, no reset needed
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
   end

   assign rd_data = vld_q[rd_addr] ? mem_q[rd_addr] : '0;

endmodule : pool_row_buffer

// File: rtl/conv_pool_stage.sv
// Bias + ReLU + 2x2 stride-2 max pooling on a channel/row/column pixel stream.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, cfg_*, bias  : job launch and configuration (latched on start)
//   quant_shift         : requantization shift (CONV_POOL_QUANT_EN builds only)
//   in_valid/ready/data : conv pixel stream in
//   out_valid/ready/data/last : pooled pixel stream out
//   busy, done, cfg_err : job status
// Build option: define CONV_POOL_QUANT_EN to shift and saturate pooled values to 0..127.
module conv_pool_stage
   import cnn_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned MAX_W  = 64,
   parameter int unsigned MAX_OF = MAX_OF_DEF
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic [7:0]                     cfg_w,
   input  logic [7:0]                     cfg_h,
   input  logic [7:0]                     cfg_nof,
   input  logic [MAX_OF-1:0][DATA_W-1:0]  bias,
   input  logic [4:0]                     quant_shift,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic signed [DATA_W-1:0]       in_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [DATA_W-1:0]              out_data,
   output logic                           out_last,
   output logic                           busy,
   output logic                           done,
   output logic                           cfg_err
);

   localparam int unsigned DEPTH = MAX_W / 2;
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CHW   = (MAX_OF > 1) ? $clog2(MAX_OF) : 1;

   pool_state_t state_q, state_d;

   logic [7:0]                    w_q, w_d, h_q, h_d, nof_q, nof_d;
   logic [MAX_OF-1:0][DATA_W-1:0] bias_q, bias_d;
   logic [7:0]                    col_q, col_d, row_q, row_d, ch_q, ch_d;
   logic signed [DATA_W-1:0]      pair_q, pair_d;
   logic                          out_valid_q, out_valid_d;
   logic                          out_last_q, out_last_d;
   logic [DATA_W-1:0]             out_data_q, out_data_d;
   logic                          busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;

   logic                          cfg_ok_c, start_c, in_hs_c, out_hs_c;
   logic                          col_last_c, row_last_c, ch_last_c;
   logic signed [DATA_W-1:0]      sum_c, v_c, pair_max_c, rb_rd_c, pool_c, result_c;
   logic                          rb_we_c;
   logic [AW-1:0]                 rb_addr_c;

   // Configuration legality
   assign cfg_ok_c = !cfg_w[0] && (cfg_w != 8'd0) && (32'(cfg_w) <= MAX_W) &&
                     !cfg_h[0] && (cfg_h != 8'd0) &&
                     (cfg_nof != 8'd0) && (32'(cfg_nof) <= MAX_OF);

   assign start_c    = (state_q == IDLE) && start;
   assign in_ready   = busy_q && ((state_q == EVEN_ROW) || (state_q == ODD_ROW)) &&
                       !(out_valid_q && !out_ready);
   assign in_hs_c    = in_valid && in_ready;
   assign out_hs_c   = out_valid_q && out_ready;
   assign col_last_c = (col_q == w_q - 8'd1);
   assign row_last_c = (row_q == h_q - 8'd1);
   assign ch_last_c  = (ch_q == nof_q - 8'd1);

   // Bias add wraps at DATA_W; ReLU clamps negatives so every pooled operand is >= 0
   assign sum_c      = in_data + $signed(bias_q[CHW'(ch_q)]);
   assign v_c        = sum_c[DATA_W-1] ? '0 : sum_c;
   assign pair_max_c = (v_c > pair_q) ? v_c : pair_q;
   assign pool_c     = (rb_rd_c > pair_max_c) ? rb_rd_c : pair_max_c;
   assign rb_addr_c  = AW'(col_q >> 1);

`ifdef CONV_POOL_QUANT_EN
   logic [4:0]               shift_q, shift_d;
   logic signed [DATA_W-1:0] shifted_c;

   assign shift_d   = start_c && cfg_ok_c ? quant_shift : shift_q;
   assign shifted_c = pool_c >>> shift_q;
   assign result_c  = (shifted_c > $signed(DATA_W'(QUANT_MAX))) ?
                      $signed(DATA_W'(QUANT_MAX)) : shifted_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) shift_q <= '0;
      else        shift_q <= shift_d;
   end
`else
   logic unused_quant;
   assign unused_quant = ^quant_shift;
   assign result_c     = pool_c;
`endif

   pool_row_buffer #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_row_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (rb_we_c),
      .wr_addr (rb_addr_c),
      .wr_data (pair_max_c),
      .rd_addr (rb_addr_c),
      .rd_data (rb_rd_c)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (start) state_d = cfg_ok_c ? EVEN_ROW : FIN;
         EVEN_ROW: if (in_hs_c && col_last_c) state_d = ODD_ROW;
         ODD_ROW:  if (in_hs_c && col_last_c)
                      state_d = (row_last_c && ch_last_c) ? FLUSH : EVEN_ROW;
         FLUSH:    if (out_hs_c) state_d = FIN;
         FIN:      state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Status outputs; done/cfg_err land in the cycle the FSM sits in FIN
   always_comb begin
      busy_d    = (state_d == EVEN_ROW) || (state_d == ODD_ROW) || (state_d == FLUSH);
      done_d    = (state_d == FIN);
      cfg_err_d = start_c && !cfg_ok_c;
   end

   // Datapath: config latch, counters, pair register and output register
   always_comb begin
      w_d         = w_q;
      h_d         = h_q;
      nof_d       = nof_q;
      bias_d      = bias_q;
      col_d       = col_q;
      row_d       = row_q;
      ch_d        = ch_q;
      pair_d      = pair_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      rb_we_c     = 1'b0;

      if (start_c && cfg_ok_c) begin
         w_d    = cfg_w;
         h_d    = cfg_h;
         nof_d  = cfg_nof;
         bias_d = bias;
         col_d  = '0;
         row_d  = '0;
         ch_d   = '0;
         pair_d = '0;
      end

      if (out_hs_c) begin
         out_valid_d = 1'b0;
         out_data_d  = '0;
         out_last_d  = 1'b0;
      end

      // A new emit overrides the clear so back-to-back outputs keep out_valid high
      if (in_hs_c) begin
         if (!col_q[0]) begin
            pair_d = v_c;
         end else if (state_q == ODD_ROW) begin
            out_valid_d = 1'b1;
            out_data_d  = result_c;
            out_last_d  = ch_last_c && row_last_c && col_last_c;
         end else begin
            rb_we_c = 1'b1;
         end

         if (col_last_c) begin
            col_d = '0;
            if (row_last_c) begin
               row_d = '0;
               ch_d  = ch_last_c ? 8'd0 : ch_q + 8'd1;
            end else begin
               row_d = row_q + 8'd1;
            end
         end else begin
            col_d = col_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_q         <= '0;
         h_q         <= '0;
         nof_q       <= '0;
         bias_q      <= '0;
         col_q       <= '0;
         row_q       <= '0;
         ch_q        <= '0;
         pair_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         w_q         <= w_d;
         h_q         <= h_d;
         nof_q       <= nof_d;
         bias_q      <= bias_d;
         col_q       <= col_d;
         row_q       <= row_d;
         ch_q        <= ch_d;
         pair_q      <= pair_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign cfg_err   = cfg_err_q;

endmodule : conv_pool_stage

// File: tb/tb_conv_pool_stage.sv
// Self-checking bench for conv_pool_stage: directed vector table, multi-cycle
// corner sequences and randomized jobs scored against a pooling model.
module tb_conv_pool_stage;

   localparam int MAX_OF = 8;
   localparam int BUDGET = 4000;

   logic                      clk = 1'b0;
   logic                      rst_n;
   logic                      start;
   logic [7:0]                cfg_w, cfg_h, cfg_nof;
   logic [MAX_OF-1:0][31:0]   bias_in;
   logic [4:0]                quant_shift;
   logic                      in_valid, in_ready;
   logic signed [31:0]        in_data;
   logic                      out_valid, out_ready, out_last;
   logic [31:0]               out_data;
   logic                      busy, done, cfg_err;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   conv_pool_stage #(.DATA_W(32), .MAX_W(64), .MAX_OF(MAX_OF)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cfg_w(cfg_w), .cfg_h(cfg_h),
      .cfg_nof(cfg_nof), .bias(bias_in), .quant_shift(quant_shift),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .busy(busy), .done(done), .cfg_err(cfg_err)
   );

   typedef struct {
      int w, h, nof;
      int b0, b1;
      int pat;      // 0 ramp per channel, 1 ch0 ramp / ch1 -200, 2 {p0,0,0,...}
      int p0;
      int qs;
      int rmode;    // 0 always ready, 1 random, 2 hold 5 cycles at first emit
      int n_exp;
      int exp_v[8];
   } vec_t;

   task automatic chk(input string nm, input longint act, input longint exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
      end
   endtask

   // Reference: pool each 2x2 window of ReLU(pixel + bias), channel-major order
   function automatic void model(input int w, input int h, input int nof,
                                 input int b[MAX_OF], input int qs,
                                 input int pix[$], output int exp_q[$]);
      exp_q.delete();
      for (int c = 0; c < nof; c++)
         for (int py = 0; py < h / 2; py++)
            for (int px = 0; px < w / 2; px++) begin
               int m;
               m = 0;
               for (int dy = 0; dy < 2; dy++)
                  for (int dx = 0; dx < 2; dx++) begin
                     int s;
                     s = pix[c*w*h + (2*py+dy)*w + 2*px + dx] + b[c];
                     if (s < 0) s = 0;
                     if (s > m) m = s;
                  end
`ifdef CONV_POOL_QUANT_EN
               m = m >>> qs;
               if (m > 127) m = 127;
`endif
               exp_q.push_back(m);
            end
   endfunction

   task automatic run_job(input string tag, input int w, input int h, input int nof,
                          input int b[MAX_OF], input int qs, input int pix[$],
                          input int rmode, input bit gaps, input int exp_q[$]);
      int got_d[$];
      int got_l[$];
      int idx, cyc, hs_cyc, done_cyc, hold, held;
      bit started;
      idx = 0; cyc = 0; hs_cyc = -1; done_cyc = -1; hold = 0; held = 0; started = 0;

      @(negedge clk);
      cfg_w = 8'(w); cfg_h = 8'(h); cfg_nof = 8'(nof); quant_shift = 5'(qs);
      for (int i = 0; i < MAX_OF; i++) bias_in[i] = b[i];
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, " busy_after_start"}, busy, 1);

      while (cyc < BUDGET && done_cyc < 0) begin
         if (idx < pix.size() && (!gaps || $urandom_range(0, 3) != 0)) begin
            in_valid = 1'b1; in_data = pix[idx];
         end else begin
            in_valid = 1'b0; in_data = $urandom;
         end
         case (rmode)
            1: out_ready = ($urandom_range(0, 3) != 0);
            2: begin
               if (!started && out_valid) begin started = 1; hold = 5; end
               if (hold > 0) begin out_ready = 1'b0; hold--; held++; end
               else out_ready = 1'b1;
            end
            default: out_ready = 1'b1;
         endcase
         #1;
         if (out_valid && !out_ready) chk({tag, " stall_in_ready"}, in_ready, 0);
         if (in_valid && in_ready) idx++;
         if (out_valid && out_ready) begin
            got_d.push_back(int'(out_data));
            got_l.push_back(int'(out_last));
            hs_cyc = cyc;
         end
         if (done) done_cyc = cyc;
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;

      chk({tag, " done_seen"}, (done_cyc >= 0), 1);
      chk({tag, " done_latency"}, done_cyc - hs_cyc, 1);
      chk({tag, " busy_after_done"}, busy, 0);
      chk({tag, " done_pulse"}, done, 0);
      chk({tag, " pixels_taken"}, idx, pix.size());
      if (rmode == 2) chk({tag, " held_cycles"}, held, 5);
      chk({tag, " out_count"}, got_d.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
         chk($sformatf("%s data[%0d]", tag, i), got_d[i], exp_q[i]);
         chk($sformatf("%s last[%0d]", tag, i), got_l[i], (i == exp_q.size() - 1) ? 1 : 0);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " in_ready"}, in_ready, 0);
      chk({tag, " out_valid"}, out_valid, 0);
      chk({tag, " out_data"}, out_data, 0);
      chk({tag, " out_last"}, out_last, 0);
      chk({tag, " busy"}, busy, 0);
      chk({tag, " done"}, done, 0);
      chk({tag, " cfg_err"}, cfg_err, 0);
   endtask

   initial begin
      vec_t vecs[6];
      int   n_vec;
      int   b[MAX_OF];
      int   pix[$];
      int   exp_q[$];
      int   acc, cyc;

      rst_n = 1'b0; start = 1'b0; cfg_w = '0; cfg_h = '0; cfg_nof = '0;
      bias_in = '0; quant_shift = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

      vecs[0] = '{4, 4, 1, 0,   0,   0, 0,    0, 0, 4, '{5, 7, 13, 15, 0, 0, 0, 0}};
      vecs[1] = '{4, 4, 1, -10, 0,   0, 0,    0, 0, 4, '{0, 0, 3, 5, 0, 0, 0, 0}};
      vecs[2] = '{4, 4, 2, 0,   100, 1, 0,    0, 0, 8, '{5, 7, 13, 15, 0, 0, 0, 0}};
      vecs[3] = '{4, 4, 1, 0,   0,   0, 0,    0, 2, 4, '{5, 7, 13, 15, 0, 0, 0, 0}};
      n_vec = 4;
`ifdef CONV_POOL_QUANT_EN
      vecs[4] = '{2, 2, 1, 0,   0,   2, 1000, 2, 0, 1, '{127, 0, 0, 0, 0, 0, 0, 0}};
      vecs[5] = '{2, 2, 1, 0,   0,   2, 400,  2, 0, 1, '{100, 0, 0, 0, 0, 0, 0, 0}};
      n_vec = 6;
`endif

      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;

      // Directed vector table
      for (int v = 0; v < n_vec; v++) begin
         pix.delete();
         exp_q.delete();
         for (int i = 0; i < MAX_OF; i++) b[i] = 0;
         b[0] = vecs[v].b0;
         b[1] = vecs[v].b1;
         for (int c = 0; c < vecs[v].nof; c++)
            for (int i = 0; i < vecs[v].w * vecs[v].h; i++)
               case (vecs[v].pat)
                  1:       pix.push_back((c == 0) ? i : -200);
                  2:       pix.push_back((i == 0) ? vecs[v].p0 : 0);
                  default: pix.push_back(i);
               endcase
         for (int i = 0; i < vecs[v].n_exp; i++) exp_q.push_back(vecs[v].exp_v[i]);
         run_job($sformatf("vec%0d", v), vecs[v].w, vecs[v].h, vecs[v].nof, b,
                 vecs[v].qs, pix, vecs[v].rmode, 1'b0, exp_q);
      end

      // Rejected configurations: no handshakes, done+cfg_err one cycle later
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         cfg_w = (k == 0) ? 8'd3 : 8'd4; cfg_h = 8'd4; cfg_nof = (k == 0) ? 8'd1 : 8'd0;
         start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
         @(negedge clk);
         start = 1'b0;
         chk($sformatf("badcfg%0d done", k), done, 1);
         chk($sformatf("badcfg%0d cfg_err", k), cfg_err, 1);
         chk($sformatf("badcfg%0d busy", k), busy, 0);
         chk($sformatf("badcfg%0d in_ready", k), in_ready, 0);
         chk($sformatf("badcfg%0d out_valid", k), out_valid, 0);
         @(negedge clk);
         chk($sformatf("badcfg%0d done_clr", k), done, 0);
         chk($sformatf("badcfg%0d cfg_err_clr", k), cfg_err, 0);
         chk($sformatf("badcfg%0d in_ready2", k), in_ready, 0);
         in_valid = 1'b0;
      end

      // Reset in the middle of a job, then a clean job
      @(negedge clk);
      cfg_w = 8'd4; cfg_h = 8'd4; cfg_nof = 8'd1; quant_shift = '0; bias_in = '0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      acc = 0; cyc = 0;
      while (acc < 6 && cyc < 100) begin
         in_valid = 1'b1; in_data = acc; out_ready = 1'b1;
         #1;
         if (in_ready) acc++;
         @(negedge clk);
         cyc++;
      end
      chk("midreset accepted", acc, 6);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk_all_zero("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      pix.delete();
      for (int i = 0; i < 16; i++) pix.push_back(i);
      for (int i = 0; i < MAX_OF; i++) b[i] = 0;
      exp_q = '{5, 7, 13, 15};
      run_job("after_reset", 4, 4, 1, b, 0, pix, 0, 1'b0, exp_q);

      // Randomized jobs with gaps and random back-pressure
      for (int r = 0; r < 8; r++) begin
         int w, h, nof, qs;
         w   = 2 * $urandom_range(1, 5);
         h   = 2 * $urandom_range(1, 3);
         nof = $urandom_range(1, 3);
         qs  = $urandom_range(0, 4);
         for (int i = 0; i < MAX_OF; i++) b[i] = $urandom_range(0, 200) - 100;
         pix.delete();
         for (int i = 0; i < w * h * nof; i++)
            pix.push_back(($urandom_range(0, 15) == 0) ? int'($urandom) :
                          $urandom_range(0, 400) - 200);
         model(w, h, nof, b, qs, pix, exp_q);
         run_job($sformatf("rand%0d", r), w, h, nof, b, qs, pix, 1, 1'b1, exp_q);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule : tb_conv_pool_stage
